// File: rtl/la_test_progress_reporter.sv
`default_nettype none
// ============================================================================
// Module   : la_test_progress_reporter
// Purpose  : Drives the test-progress pads watched by the DV benches. Firmware
//            issues step commands over the logic analyser. Each accepted step
//            is reported as BUSY for HOLD_CYCLES cycles and then as DONE or
//            FAIL. The block checks that steps arrive in order and mirrors its
//            state back on la_data_out.
// Ports    : wb_clk_i    - single clock
//            wb_rst_i    - asynchronous active-high reset
//            la_data_in  - [5:0] requested step, [6] strobe toggle,
//                          [7] fail flag, [8] abort
//            la_oenb     - LA output enables, active-low; commands are only
//                          taken while la_oenb[8:0] == 0
//            la_data_out - [5:0] step, [7:6] status, [15:8] error count,
//                          [16] overrun, [17] busy, all other bits 0
//            io_out      - step code at STEP_LSB, status at STAT_LSB
//            io_oeb      - constant pad enables, driven only on the used bits
// Revision : 1.0 - initial release
// ============================================================================
module la_test_progress_reporter #(
    parameter int STEP_W      = 6,
    parameter int MAX_STEP    = 16,
    parameter int HOLD_CYCLES = 16,
    parameter int STEP_LSB    = 20,
    parameter int STAT_LSB    = 36
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [31:0] la_data_in,
    input  logic [31:0] la_oenb,
    output logic [31:0] la_data_out,
    output logic [37:0] io_out,
    output logic [37:0] io_oeb
);

    // The state encoding is the pad status code, so the status pins come
    // straight off the state flops.
    typedef enum logic [1:0] {
        ST_DONE = 2'b00,
        ST_FAIL = 2'b01,
        ST_BUSY = 2'b10,
        ST_IDLE = 2'b11
    } state_t;

    localparam int                CNT_W       = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  C_HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [STEP_W:0]   C_MAX_STEP  = (STEP_W + 1)'(MAX_STEP);

    state_t            state_q,   state_d;
    logic [STEP_W-1:0] step_q,    step_d;
    logic [7:0]        err_cnt_q, err_cnt_d;
    logic              overrun_q, overrun_d;
    logic              fail_q,    fail_d;
    logic              tgl_q,     tgl_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;

    logic [STEP_W-1:0] w_req;
    logic              w_strobe;
    logic              w_fail_in;
    logic              w_abort;
    logic              w_evt;
    logic [STEP_W:0]   w_step_inc;
    logic [7:0]        w_err_inc;

    assign w_req      = la_data_in[STEP_W-1:0];
    assign w_strobe   = la_data_in[6];
    assign w_fail_in  = la_data_in[7];
    assign w_abort    = la_data_in[8];
    // tgl_q tracks the strobe even while the gate is closed, so a toggle made
    // while closed is absorbed and never fires later.
    assign w_evt      = (w_strobe != tgl_q) && (la_oenb[8:0] == 9'd0);
    assign w_step_inc = {1'b0, step_q} + {{STEP_W{1'b0}}, 1'b1};
    assign w_err_inc  = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;

    // Upper LA bits carry no command.
    logic unused_ok;
    assign unused_ok = ^{la_data_in[31:9], la_oenb[31:9]};

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        err_cnt_d = err_cnt_q;
        overrun_d = overrun_q;
        fail_d    = fail_q;
        tgl_d     = w_strobe;
        cnt_d     = cnt_q;

        // Hold timer. It loads HOLD_CYCLES-1 on entry, so BUSY lasts exactly
        // HOLD_CYCLES cycles.
        if (state_q == ST_BUSY) begin
            if (cnt_q == '0) begin
                state_d = fail_q ? ST_FAIL : ST_DONE;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end

        // Commands override the timer only through abort or restart. A
        // command arriving while BUSY just flags overrun and lets the timer
        // run on.
        if (w_evt) begin
            if (w_abort || (w_req == '0)) begin
                step_d    = '0;
                state_d   = ST_IDLE;
                overrun_d = 1'b0;
            end else if (state_q == ST_BUSY) begin
                overrun_d = 1'b1;
            end else if (state_q == ST_FAIL) begin
                err_cnt_d = w_err_inc;
            end else if (({1'b0, w_req} == w_step_inc) && ({1'b0, w_req} <= C_MAX_STEP)) begin
                step_d  = w_req;
                fail_d  = w_fail_in;
                state_d = ST_BUSY;
                cnt_d   = C_HOLD_LOAD;
            end else begin
                state_d   = ST_FAIL;
                err_cnt_d = w_err_inc;
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= ST_IDLE;
            step_q    <= '0;
            err_cnt_q <= 8'd0;
            overrun_q <= 1'b0;
            fail_q    <= 1'b0;
            tgl_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            err_cnt_q <= err_cnt_d;
            overrun_q <= overrun_d;
            fail_q    <= fail_d;
            tgl_q     <= tgl_d;
            cnt_q     <= cnt_d;
        end
    end

    // All outputs are plain wiring of flop values, so they are consistent
    // with each other in every cycle.
    always_comb begin
        io_out                        = '0;
        io_out[STEP_LSB +: STEP_W]    = step_q;
        io_out[STAT_LSB +: 2]         = state_q;

        io_oeb                        = '1;
        io_oeb[STEP_LSB +: STEP_W]    = '0;
        io_oeb[STAT_LSB +: 2]         = 2'b00;
    end

    assign la_data_out = {14'b0, (state_q == ST_BUSY), overrun_q, err_cnt_q, state_q, step_q};

endmodule
`default_nettype wire
